// File: rtl/idex_hazard_stage.sv
// idex_hazard_stage: ID/EX pipeline register with load-use and ID-branch hazard detection
// Ports: id_* decoded ID-stage instruction; EXMEM_rd/EXMEM_MemRead describe the EX/MEM occupant;
// IDEX_* registered fields for EX and forwarding; stall_id holds PC and IF/ID; bubble flags a
// bubble entering ID/EX this cycle; mem_stall freezes everything.
module idex_hazard_stage #(
  parameter int XLEN = 32,
  parameter int ALUC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_stall,
  input  logic              id_flush,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_is_branch,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_MemtoReg,
  input  logic              id_ALUSrc,
  input  logic [ALUC_W-1:0] id_ALUCtrl,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        EXMEM_rd,
  input  logic              EXMEM_MemRead,
  output logic              IDEX_valid,
  output logic              IDEX_RegWrite,
  output logic              IDEX_MemRead,
  output logic              IDEX_MemWrite,
  output logic              IDEX_MemtoReg,
  output logic              IDEX_ALUSrc,
  output logic [ALUC_W-1:0] IDEX_ALUCtrl,
  output logic [4:0]        IDEX_rs1,
  output logic [4:0]        IDEX_rs2,
  output logic [4:0]        IDEX_rd,
  output logic [XLEN-1:0]   IDEX_rs1_data,
  output logic [XLEN-1:0]   IDEX_rs2_data,
  output logic [XLEN-1:0]   IDEX_imm,
  output logic [XLEN-1:0]   IDEX_pc,
  output logic              stall_id,
  output logic              bubble
);
  logic live, use_ex, use_mem, hz_ld, hz_br_ex, hz_br_mem, hazard;
  assign live = id_valid & ~id_flush;
  // ID actually reads the destination held in EX / MEM; x0 never matches
  assign use_ex = |IDEX_rd & ((id_use_rs1 & (id_rs1 == IDEX_rd)) | (id_use_rs2 & (id_rs2 == IDEX_rd)));
  assign use_mem = |EXMEM_rd & ((id_use_rs1 & (id_rs1 == EXMEM_rd)) | (id_use_rs2 & (id_rs2 == EXMEM_rd)));
  assign hz_ld = live & IDEX_MemRead & use_ex;
  // branches resolve in ID and can only forward from EX/MEM and MEM/WB
  assign hz_br_ex = live & id_is_branch & IDEX_RegWrite & use_ex;
  assign hz_br_mem = live & id_is_branch & EXMEM_MemRead & use_mem;
  assign hazard = hz_ld | hz_br_ex | hz_br_mem;
  assign stall_id = mem_stall | hazard;
  assign bubble = ~mem_stall & (hazard | id_flush | ~id_valid);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      IDEX_valid    <= 1'b0;
      IDEX_RegWrite <= 1'b0;
      IDEX_MemRead  <= 1'b0;
      IDEX_MemWrite <= 1'b0;
      IDEX_MemtoReg <= 1'b0;
      IDEX_ALUSrc   <= 1'b0;
      IDEX_ALUCtrl  <= '0;
      IDEX_rs1      <= '0;
      IDEX_rs2      <= '0;
      IDEX_rd       <= '0;
      IDEX_rs1_data <= '0;
      IDEX_rs2_data <= '0;
      IDEX_imm      <= '0;
      IDEX_pc       <= '0;
    end else if (!mem_stall) begin
      IDEX_valid    <= ~bubble;
      IDEX_RegWrite <= ~bubble & id_RegWrite;
      IDEX_MemRead  <= ~bubble & id_MemRead;
      IDEX_MemWrite <= ~bubble & id_MemWrite;
      IDEX_MemtoReg <= ~bubble & id_MemtoReg;
      IDEX_ALUSrc   <= ~bubble & id_ALUSrc;
      IDEX_ALUCtrl  <= bubble ? '0 : id_ALUCtrl;
      IDEX_rs1      <= bubble ? '0 : id_rs1;
      IDEX_rs2      <= bubble ? '0 : id_rs2;
      IDEX_rd       <= bubble ? '0 : id_rd;
      IDEX_rs1_data <= bubble ? '0 : id_rs1_data;
      IDEX_rs2_data <= bubble ? '0 : id_rs2_data;
      IDEX_imm      <= bubble ? '0 : id_imm;
      IDEX_pc       <= bubble ? '0 : id_pc;
    end
endmodule

// File: tb/tb_idex_hazard_stage.sv
// tb_idex_hazard_stage: scoreboard bench for idex_hazard_stage with a behavioural pipeline model
module tb_idex_hazard_stage;
  typedef struct packed {
    logic v, rw, mr, mw, mtr, as;
    logic [3:0] aluc;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
  } idex_t;
  typedef struct packed {
    logic stall, bub;
    idex_t r;
  } exp_t;
  logic clk, rst, mem_stall, id_flush, id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd, EXMEM_rd;
  logic id_use_rs1, id_use_rs2, id_is_branch, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc;
  logic [3:0] id_ALUCtrl;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic EXMEM_MemRead;
  logic IDEX_valid, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc;
  logic [3:0] IDEX_ALUCtrl;
  logic [4:0] IDEX_rs1, IDEX_rs2, IDEX_rd;
  logic [31:0] IDEX_rs1_data, IDEX_rs2_data, IDEX_imm, IDEX_pc;
  logic stall_id, bubble;
  idex_t dut_o, m;
  logic [4:0] ex_rd;
  logic ex_mr;
  exp_t q[$];
  int tests = 0, fails = 0;
  idex_hazard_stage #(.XLEN(32), .ALUC_W(4)) dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .id_flush(id_flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_branch(id_is_branch), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg), .id_ALUSrc(id_ALUSrc), .id_ALUCtrl(id_ALUCtrl),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .EXMEM_rd(EXMEM_rd), .EXMEM_MemRead(EXMEM_MemRead),
    .IDEX_valid(IDEX_valid), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_MemWrite(IDEX_MemWrite), .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_ALUSrc(IDEX_ALUSrc),
    .IDEX_ALUCtrl(IDEX_ALUCtrl), .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd),
    .IDEX_rs1_data(IDEX_rs1_data), .IDEX_rs2_data(IDEX_rs2_data), .IDEX_imm(IDEX_imm), .IDEX_pc(IDEX_pc),
    .stall_id(stall_id), .bubble(bubble)
  );
  assign dut_o = {IDEX_valid, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc,
                  IDEX_ALUCtrl, IDEX_rs1, IDEX_rs2, IDEX_rd, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm, IDEX_pc};
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(string n, logic [159:0] act, logic [159:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %h want %h", n, $time, act, req);
    end
  endtask
  // does the ID instruction read architectural register r (x0 is never a dependence)
  function automatic bit reads(logic [4:0] r);
    return r != 0 && ((id_use_rs1 && id_rs1 == r) || (id_use_rs2 && id_rs2 == r));
  endfunction
  // issue one cycle of ID inputs: predict the response, advance the model pipeline
  task automatic step();
    exp_t e;
    bit must_wait;
    EXMEM_rd = ex_rd;
    EXMEM_MemRead = ex_mr;
    must_wait = id_valid && !id_flush &&
                ((m.mr && reads(m.rd)) ||
                 (id_is_branch && m.rw && reads(m.rd)) ||
                 (id_is_branch && ex_mr && reads(ex_rd)));
    e.stall = mem_stall || must_wait;
    e.bub = !mem_stall && (must_wait || id_flush || !id_valid);
    if (mem_stall) e.r = m;
    else if (e.bub) e.r = '0;
    else e.r = {1'b1, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_ALUCtrl,
                id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc};
    if (!mem_stall) begin
      ex_rd = m.rd;
      ex_mr = m.mr;
    end
    m = e.r;
    q.push_back(e);
    @(negedge clk);
  endtask
  task automatic set_id(bit v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, bit u1, bit u2,
                        bit br, bit rw, bit mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_use_rs1 = u1; id_use_rs2 = u2;
    id_is_branch = br; id_RegWrite = rw; id_MemRead = mr; id_MemWrite = 0; id_MemtoReg = mr;
    id_ALUSrc = 1'($urandom); id_ALUCtrl = 4'($urandom);
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
    id_flush = 0; mem_stall = 0;
  endtask
  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q[0];
        chk("stall_id", 160'(stall_id), 160'(e.stall));
        chk("bubble", 160'(bubble), 160'(e.bub));
        @(posedge clk);
        #1;
        chk("idex", 160'(dut_o), 160'(e.r));
        void'(q.pop_front());
      end
    end
  end
  initial begin
    rst = 1; ex_rd = 0; ex_mr = 0; m = '0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    EXMEM_rd = 0; EXMEM_MemRead = 0;
    #3;
    chk("reset_idex", 160'(dut_o), 160'(0));
    @(negedge clk);
    rst = 0;
    set_id(1, 1, 2, 5, 1, 1, 0, 1, 0); step();
    set_id(1, 0, 0, 5, 0, 0, 0, 1, 1); step();
    set_id(1, 5, 7, 6, 1, 1, 0, 1, 0); steps(2);
    set_id(1, 0, 0, 3, 0, 0, 0, 1, 1); step();
    set_id(1, 3, 0, 0, 1, 1, 1, 0, 0); steps(3);
    set_id(1, 1, 2, 4, 1, 1, 0, 1, 0); step();
    set_id(1, 4, 1, 0, 1, 1, 1, 0, 0); steps(2);
    set_id(1, 1, 2, 0, 1, 1, 0, 1, 0); step();
    set_id(1, 0, 1, 0, 1, 1, 1, 0, 0); step();
    set_id(1, 9, 5, 8, 1, 0, 0, 1, 0); step();
    set_id(1, 0, 0, 5, 0, 0, 0, 1, 1); step();
    set_id(1, 9, 5, 8, 1, 0, 0, 1, 0); step();
    set_id(1, 5, 7, 6, 1, 1, 0, 1, 0); mem_stall = 1; steps(3);
    mem_stall = 0; steps(2);
    set_id(1, 0, 0, 5, 0, 0, 0, 1, 1); step();
    set_id(1, 5, 7, 6, 1, 1, 0, 1, 0); id_flush = 1; step();
    set_id(1, 0, 0, 5, 0, 0, 0, 1, 1); step();
    set_id(1, 5, 7, 6, 1, 1, 0, 1, 0); step();
    #3 rst = 1;
    #1 chk("midstall_reset", 160'(dut_o), 160'(0));
    m = '0; ex_rd = 0; ex_mr = 0;
    @(negedge clk);
    rst = 0;
    set_id(1, 1, 2, 5, 1, 1, 0, 1, 0); step();
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
             1'($urandom), $urandom_range(0, 2) == 0);
      id_MemWrite = 1'($urandom);
      id_flush = $urandom_range(0, 9) == 0;
      mem_stall = $urandom_range(0, 6) == 0;
      step();
    end
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses never checked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
